// File: rtl/mii_pkg.sv
// Shared codes, state/error enums and lane constants for the MII RX frame assembler.
package mii_pkg;

  localparam int          LANES   = 8;
  localparam int          LANE_W  = 8;
  localparam int          CNT_W   = 11;

  localparam logic [7:0]  IDLE_C  = 8'h07;
  localparam logic [7:0]  START_C = 8'hFB;
  localparam logic [7:0]  TERM_C  = 8'hFD;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_asm_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TRUNC   = 2'd1,
    ERR_OVF     = 2'd2,
    ERR_RESTART = 2'd3
  } rx_err_e;

  // Byte-count add that pins at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add11(input logic [CNT_W-1:0] a,
                                                  input logic [3:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mii_term_lane_finder.sv
// Combinational scan of one MII word: lowest TERM lane, stray control before it,
// and a START sitting in lane 0.
module mii_term_lane_finder
  import mii_pkg::*;
#(
  parameter int         LANES_P    = 8,
  parameter logic [7:0] START_CODE = START_C,
  parameter logic [7:0] TERM_CODE  = TERM_C
) (
  input  logic [LANES_P*8-1:0] data_i,
  input  logic [LANES_P-1:0]   ctrl_i,
  output logic                 term_found_o,
  output logic [2:0]           term_lane_o,
  output logic                 ctrl_err_o,
  output logic                 start_l0_o
);

  logic [LANES_P-1:0][7:0] lane;
  logic                    found;
  logic [2:0]              tl;
  logic                    cerr;

  assign lane = data_i;

  // Priority scan from lane 0 up; controls after the first TERM are don't-care.
  always_comb begin
    found = 1'b0;
    tl    = '0;
    cerr  = 1'b0;
    for (int k = 0; k < LANES_P; k++) begin
      if (ctrl_i[k] && !found) begin
        if (lane[k] == TERM_CODE) begin
          found = 1'b1;
          tl    = 3'(k);
        end else if (!(k == 0 && lane[k] == START_CODE)) begin
          cerr = 1'b1;
        end
      end
    end
  end

  assign term_found_o = found;
  assign term_lane_o  = tl;
  assign ctrl_err_o   = cerr;
  assign start_l0_o   = ctrl_i[0] && (lane[0] == START_CODE);

endmodule

// File: rtl/mii_rx_frame_assembler.sv
// Packs 64-bit MII data/ctrl words into a flat frame buffer, START..TERM inclusive.
// Optional RX_ASM_STATS_EN adds good/error frame counters.
module mii_rx_frame_assembler
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH      = 64,
  parameter int         CTRL_WIDTH      = 8,
  parameter int         MAX_FRAME_BYTES = 1536,
  parameter logic [7:0] START_CODE      = START_C,
  parameter logic [7:0] TERM_CODE       = TERM_C
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic [DATA_WIDTH-1:0]        i_rx_data,
  input  logic [CTRL_WIDTH-1:0]        i_rx_ctrl,
  output logic [MAX_FRAME_BYTES*8-1:0] o_frame_data,
  output logic [10:0]                  o_frame_bytes,
  output logic                         o_frame_valid,
  output logic                         o_frame_err,
  output logic [1:0]                   o_err_code
`ifdef RX_ASM_STATS_EN
  ,
  output logic [31:0]                  o_good_cnt,
  output logic [31:0]                  o_err_cnt
`endif
);

  localparam int NL = CTRL_WIDTH;

  rx_asm_state_e                  state_q, state_d;
  logic [10:0]                    cnt_q, cnt_d;
  logic                           valid_q, valid_d;
  logic                           err_q, err_d;
  rx_err_e                        code_q, code_d;
  logic [MAX_FRAME_BYTES-1:0][7:0] buf_q;

  logic                           buf_clr;
  logic [3:0]                     wr_n;
  logic [10:0]                    wr_base;
  logic [NL-1:0][10:0]            wr_idx;
  logic [NL-1:0][7:0]             lane;

  logic                           term_found;
  logic [2:0]                     term_lane;
  logic                           ctrl_err;
  logic                           start_l0;
  logic [3:0]                     n_app;
  logic [10:0]                    sum;
  logic                           ovf;

  assign lane = i_rx_data;

  mii_term_lane_finder #(
    .LANES_P    (NL),
    .START_CODE (START_CODE),
    .TERM_CODE  (TERM_CODE)
  ) u_finder (
    .data_i       (i_rx_data),
    .ctrl_i       (i_rx_ctrl),
    .term_found_o (term_found),
    .term_lane_o  (term_lane),
    .ctrl_err_o   (ctrl_err),
    .start_l0_o   (start_l0)
  );

  // Lanes this word would contribute, and the resulting (saturated) count.
  assign n_app = term_found ? ({1'b0, term_lane} + 4'd1) : 4'(NL);
  assign sum   = sat_add11(cnt_q, n_app);
  assign ovf   = sum > 11'(MAX_FRAME_BYTES);

  // Next-state, pulse and buffer-write control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    buf_clr = 1'b0;
    wr_n    = '0;
    wr_base = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A START sharing its word with a TERM is not a frame.
        if (start_l0 && !term_found) begin
          state_d = RECV;
          buf_clr = 1'b1;
          wr_base = '0;
          wr_n    = 4'(NL);
          cnt_d   = 11'(NL);
        end
      end
      RECV: begin
        if (ctrl_err) begin
          err_d   = 1'b1;
          code_d  = ERR_TRUNC;
          state_d = IDLE;
        end else if (start_l0 && !term_found) begin
          // Restart: this word becomes byte 0 of a fresh capture.
          err_d   = 1'b1;
          code_d  = ERR_RESTART;
          buf_clr = 1'b1;
          wr_base = '0;
          wr_n    = 4'(NL);
          cnt_d   = 11'(NL);
        end else if (ovf) begin
          err_d   = 1'b1;
          code_d  = ERR_OVF;
          state_d = DROP;
        end else begin
          wr_n  = n_app;
          cnt_d = sum;
          if (term_found) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (term_found || (&i_rx_ctrl)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane write address into the flat buffer.
  always_comb begin
    for (int k = 0; k < NL; k++) wr_idx[k] = wr_base + 11'(k);
  end

  // FSM, byte count and pulse registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Frame buffer: optional clear, then lane writes at the running offset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q <= '0;
    end else begin
      if (buf_clr) buf_q <= '0;
      for (int k = 0; k < NL; k++) begin
        if (4'(k) < wr_n) buf_q[wr_idx[k]] <= lane[k];
      end
    end
  end

  assign o_frame_data  = buf_q;
  assign o_frame_bytes = cnt_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_err_code    = code_q;

`ifdef RX_ASM_STATS_EN
  logic [31:0] good_q, bad_q;

  // Free-running frame outcome counters, wrap modulo 2^32.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (valid_q) good_q <= good_q + 32'd1;
      if (err_q)   bad_q  <= bad_q + 32'd1;
    end
  end

  assign o_good_cnt = good_q;
  assign o_err_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_mii_rx_frame_assembler.sv
// Scoreboard bench for mii_rx_frame_assembler: random/directed MII words, byte-list model.
module tb_mii_rx_frame_assembler;
  import mii_pkg::*;

  localparam int MAXB = 1536;
  localparam int FW   = MAXB * 8;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [63:0]   i_rx_data;
  logic [7:0]    i_rx_ctrl;
  logic [FW-1:0] o_frame_data;
  logic [10:0]   o_frame_bytes;
  logic          o_frame_valid;
  logic          o_frame_err;
  logic [1:0]    o_err_code;
`ifdef RX_ASM_STATS_EN
  logic [31:0]   o_good_cnt;
  logic [31:0]   o_err_cnt;
`endif

  always #5 clk = ~clk;

  mii_rx_frame_assembler dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_rx_data     (i_rx_data),
    .i_rx_ctrl     (i_rx_ctrl),
    .o_frame_data  (o_frame_data),
    .o_frame_bytes (o_frame_bytes),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err),
    .o_err_code    (o_err_code)
`ifdef RX_ASM_STATS_EN
    ,
    .o_good_cnt    (o_good_cnt),
    .o_err_cnt     (o_err_cnt)
`endif
  );

  typedef struct {
    bit            is_err;
    logic [1:0]    code;
    int            cyc;
    int            nbytes;
    logic [FW-1:0] data;
  } ev_t;

  ev_t        sbq[$];
  ev_t        mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;

  // Reference model: 0 waiting for START, 1 collecting, 2 discarding.
  int         mode = 0;
  logic [7:0] frm[$];
  int         m_good = 0;
  int         m_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push_ev(input bit e, input logic [1:0] code);
    ev_t ev;
    ev.is_err = e;
    ev.code   = code;
    ev.cyc    = cyc + 1;
    ev.nbytes = frm.size();
    ev.data   = '0;
    foreach (frm[i]) ev.data[8*i +: 8] = frm[i];
    sbq.push_back(ev);
    if (e) m_err++; else m_good++;
  endtask

  task automatic model_step(input logic [63:0] d, input logic [7:0] c);
    logic [7:0] b[8];
    int         t;
    bit         bad;
    bit         s0;
    for (int k = 0; k < 8; k++) b[k] = d[8*k +: 8];
    t = -1;
    for (int k = 0; k < 8; k++) if (t < 0 && c[k] && b[k] == TERM_C) t = k;
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (c[k] && b[k] != TERM_C && !(k == 0 && b[k] == START_C) && (t < 0 || k < t)) bad = 1;
    s0 = c[0] && (b[0] == START_C);
    case (mode)
      0: if (s0 && t < 0) begin
           frm.delete();
           for (int k = 0; k < 8; k++) frm.push_back(b[k]);
           mode = 1;
         end
      1: if (bad) begin
           push_ev(1, 2'd1); mode = 0;
         end else if (t >= 0) begin
           if (frm.size() + t + 1 > MAXB) begin
             push_ev(1, 2'd2); mode = 2;
           end else begin
             for (int k = 0; k <= t; k++) frm.push_back(b[k]);
             push_ev(0, 2'd0); mode = 0;
           end
         end else if (s0) begin
           push_ev(1, 2'd3);
           frm.delete();
           for (int k = 0; k < 8; k++) frm.push_back(b[k]);
         end else if (frm.size() + 8 > MAXB) begin
           push_ev(1, 2'd2); mode = 2;
         end else begin
           for (int k = 0; k < 8; k++) frm.push_back(b[k]);
         end
      default: if (t >= 0 || c == 8'hFF) mode = 0;
    endcase
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    i_rx_data = d;
    i_rx_ctrl = c;
    model_step(d, c);
  endtask

  task automatic send_idle();
    send({8{IDLE_C}}, 8'hFF);
  endtask

  task automatic send_data();
    send({$urandom, $urandom}, 8'h00);
  endtask

  task automatic send_start();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[7:0] = START_C;
    send(d, 8'h01);
  endtask

  task automatic send_term(input int t);
    logic [63:0] d;
    logic [7:0]  c;
    d = {$urandom, $urandom};
    c = 8'h00;
    d[8*t +: 8] = TERM_C;
    c[t] = 1'b1;
    for (int k = t + 1; k < 8; k++) begin
      d[8*k +: 8] = IDLE_C;
      c[k] = 1'b1;
    end
    send(d, c);
  endtask

  task automatic send_frame(input int nd, input int t);
    send_start();
    repeat (nd) send_data();
    send_term(t);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_frame_valid || o_frame_err) begin
        checks++;
        if (o_frame_valid && o_frame_err) begin
          errors++;
          $display("FAIL pulse_excl: valid=%b err=%b, required only one", o_frame_valid, o_frame_err);
        end
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: valid=%b err=%b code=%0d at cycle %0d, required no pulse",
                   o_frame_valid, o_frame_err, o_err_code, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_kind_err", 64'(o_frame_err), 64'(mon_e.is_err));
          chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.is_err) begin
            chk("err_code", 64'(o_err_code), 64'(mon_e.code));
          end else begin
            chk("frame_bytes", 64'(o_frame_bytes), 64'(mon_e.nbytes));
            checks++;
            if (o_frame_data !== mon_e.data) begin
              errors++;
              for (int i = 0; i < MAXB; i++) begin
                if (o_frame_data[8*i +: 8] !== mon_e.data[8*i +: 8]) begin
                  $display("FAIL frame_data: byte %0d got %0h, required %0h",
                           i, o_frame_data[8*i +: 8], mon_e.data[8*i +: 8]);
                  break;
                end
              end
            end
          end
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: no pulse by cycle %0d, required %s at cycle %0d",
                 cyc, sbq[0].is_err ? "err" : "valid", sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int r, nd, w;
    logic [63:0] d;
    i_rst_n   = 1'b0;
    i_rx_data = {8{IDLE_C}};
    i_rx_ctrl = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(|o_frame_data), 64'd0);
    chk("rst_bytes", 64'(o_frame_bytes), 64'd0);
    chk("rst_valid", 64'(o_frame_valid), 64'd0);
    chk("rst_err", 64'(o_frame_err), 64'd0);
    chk("rst_code", 64'(o_err_code), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    send_idle();

    // Minimum frame, TERM in lane 0.
    send(64'hD5555555555555FB, 8'h01);
    repeat (7) send_data();
    send(64'h07070707070707FD, 8'hFF);
    send_idle(); send_idle();
    @(negedge clk);
    chk("min_bytes", 64'(o_frame_bytes), 64'd65);
    chk("min_sfd", 64'(o_frame_data[63:56]), 64'hD5);
    chk("min_start", 64'(o_frame_data[7:0]), 64'hFB);

    // TERM in lane 5; lanes 6..7 are not captured.
    send_frame(3, 5);
    send_idle(); send_idle();
    @(negedge clk);
    chk("t5_bytes", 64'(o_frame_bytes), 64'd38);
    chk("t5_above_zero", 64'(|(o_frame_data >> 304)), 64'd0);
    chk("t5_term_byte", 64'(o_frame_data[37*8 +: 8]), 64'hFD);

    // IDLE after 24 bytes truncates; next frame is normal.
    send_start(); send_data(); send_data();
    send_idle(); send_idle();
    send_frame(2, 2);
    send_idle();

    // 1600 bytes with no TERM: overflow, then drop until TERM.
    send_start();
    repeat (199) send_data();
    send_term(0);
    send_idle();
    send_frame(1, 7);
    send_idle();

    // Restart via START in lane 0.
    send_start(); repeat (3) send_data();
    send_start(); repeat (4) send_data();
    send_term(3);
    send_idle(); send_idle();
    @(negedge clk);
    chk("restart_bytes", 64'(o_frame_bytes), 64'd44);

    // START and TERM in the same word: ignored.
    d = {8{8'h11}};
    d[7:0] = START_C; d[39:32] = TERM_C;
    send(d, 8'h11);
    send_data(); send_term(2); send_idle();

    // Reset in the middle of a frame.
    send_start(); repeat (3) send_data();
    @(posedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mrst_data", 64'(|o_frame_data), 64'd0);
    chk("mrst_bytes", 64'(o_frame_bytes), 64'd0);
    chk("mrst_valid", 64'(o_frame_valid), 64'd0);
    chk("mrst_err", 64'(o_frame_err), 64'd0);
    chk("mrst_code", 64'(o_err_code), 64'd0);
    chk("mrst_sb_empty", 64'(sbq.size()), 64'd0);
`ifdef RX_ASM_STATS_EN
    chk("mrst_good_cnt", 64'(o_good_cnt), 64'd0);
    chk("mrst_err_cnt", 64'(o_err_cnt), 64'd0);
`endif
    mode = 0; frm.delete(); m_good = 0; m_err = 0;
    @(negedge clk);
    i_rx_data = {8{IDLE_C}};
    i_rx_ctrl = 8'hFF;
    i_rst_n   = 1'b1;
    send_idle();
    send_frame(0, 1); send_idle();
    send_frame(2, 4); send_idle();
    send_frame(5, 6); send_idle(); send_idle();
`ifdef RX_ASM_STATS_EN
    @(negedge clk);
    chk("good_cnt_3", 64'(o_good_cnt), 64'd3);
`endif

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      r  = $urandom_range(0, 99);
      nd = $urandom_range(0, 12);
      repeat ($urandom_range(0, 2)) send_idle();
      if (r < 10) begin
        send_start(); repeat (nd) send_data(); send_idle();
      end else if (r < 20) begin
        send_start(); repeat (nd) send_data();
        send_frame($urandom_range(0, 6), $urandom_range(0, 7));
      end else if (r < 25) begin
        d = {$urandom, $urandom};
        d[7:0] = START_C; d[8*3 +: 8] = TERM_C;
        send(d, 8'h09);
        repeat (nd) send_data(); send_term($urandom_range(0, 7));
      end else begin
        send_frame(nd, $urandom_range(0, 7));
      end
    end

    repeat (4) send_idle();
    w = 0;
    while (sbq.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", 64'(sbq.size()), 64'd0);
`ifdef RX_ASM_STATS_EN
    chk("good_cnt_end", 64'(o_good_cnt), 64'(m_good));
    chk("err_cnt_end", 64'(o_err_cnt), 64'(m_err));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
